// File: rtl/muldiv.sv
// Memory-mapped 16-bit unsigned multiply/divide coprocessor on the CPU peripheral bus.
// One shift-add or restoring-divide iteration per clock, 16 clocks per operation.
module muldiv (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       irq
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [3:0] ADDR_A_L   = 4'h0;
  localparam logic [3:0] ADDR_A_H   = 4'h1;
  localparam logic [3:0] ADDR_B_L   = 4'h2;
  localparam logic [3:0] ADDR_B_H   = 4'h3;
  localparam logic [3:0] ADDR_CTRL  = 4'h4;
  localparam logic [3:0] ADDR_STAT  = 4'h5;
  localparam logic [3:0] ADDR_R0    = 4'h8;
  localparam logic [3:0] ADDR_R1    = 4'h9;
  localparam logic [3:0] ADDR_R2    = 4'hA;
  localparam logic [3:0] ADDR_R3    = 4'hB;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] opnd_q, opnd_d;
  logic [31:0] res_q, res_d;
  logic [7:0]  dout_q, dout_d;
  logic        irq_q, irq_d;

  logic        busy;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic [16:0] mul_sum;
  logic [16:0] div_shift;
  logic        div_ge;
  logic [15:0] step_hi;
  logic [15:0] step_lo;

  assign busy  = (state_q == RUN);
  assign wr_en = cs & we;
  assign rd_en = cs & ~we;

  assign rdy  = ~(cs & ~we & addr[3] & busy);
  assign dout = dout_q;
  assign irq  = irq_q;

  // One iteration: mul adds A into the high half and shifts right; div shifts the
  // 17-bit partial remainder left and subtracts B when it fits.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 17'd0);
    div_shift = {hi_q, lo_q[15]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (ctrl_q[0]) begin
      step_hi = div_ge ? (div_shift[15:0] - opnd_q) : div_shift[15:0];
      step_lo = {lo_q[14:0], div_ge};
    end else begin
      step_hi = mul_sum[16:1];
      step_lo = {mul_sum[0], lo_q[15:1]};
    end
  end

  always_comb begin
    case (addr)
      ADDR_A_L:  rd_data = a_q[7:0];
      ADDR_A_H:  rd_data = a_q[15:8];
      ADDR_B_L:  rd_data = b_q[7:0];
      ADDR_B_H:  rd_data = b_q[15:8];
      ADDR_CTRL: rd_data = ctrl_q;
      ADDR_STAT: rd_data = {busy, done_q, 5'b0, dz_q};
      ADDR_R0:   rd_data = res_q[7:0];
      ADDR_R1:   rd_data = res_q[15:8];
      ADDR_R2:   rd_data = res_q[23:16];
      ADDR_R3:   rd_data = res_q[31:24];
      default:   rd_data = 8'h00;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    done_d  = done_q;
    dz_d    = dz_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    dout_d  = dout_q;
    irq_d   = done_q & ctrl_q[7];

    if (rd_en) begin
      dout_d = rd_data;
      if (addr == ADDR_STAT) done_d = 1'b0;
    end

    if (wr_en) begin
      case (addr)
        ADDR_A_L: a_d[7:0]  = din;
        ADDR_A_H: a_d[15:8] = din;
        ADDR_B_L: b_d[7:0]  = din;
        ADDR_B_H: b_d[15:8] = din;
        ADDR_CTRL: begin
          if (busy) ctrl_d[7] = din[7];
          else      ctrl_d    = din;
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (wr_en && addr == ADDR_CTRL) begin
          state_d = RUN;
          count_d = 5'd16;
          hi_d    = 16'h0000;
          lo_d    = din[0] ? a_q : b_q;
          opnd_d  = din[0] ? b_q : a_q;
          done_d  = 1'b0;
          dz_d    = din[0] & (b_q == 16'h0000);
        end
      end
      RUN: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q - 5'd1;
        // Last iteration commits all four result bytes at once; completion beats a STATUS clear.
        if (count_q == 5'd1) begin
          res_d   = {step_hi, step_lo};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      ctrl_q  <= 8'h00;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      count_q <= 5'd0;
      hi_q    <= 16'h0000;
      lo_q    <= 16'h0000;
      opnd_q  <= 16'h0000;
      res_q   <= 32'h0000_0000;
      dout_q  <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: multiply, divide, divide-by-zero, read stall,
// busy-time writes with interrupt, and reset during an operation.
module tb_muldiv;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rdy;
  logic       irq;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .rdy  (rdy),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Each task returns 1 time unit after a rising edge, so outputs are settled.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    tick(1);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    cs = 1'b1; we = 1'b0; addr = a;
    tick(1);
    cs = 1'b0;
    v = dout;
  endtask

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
    wr(4'h0, a[7:0]);
    wr(4'h1, a[15:8]);
    wr(4'h2, b[7:0]);
    wr(4'h3, b[15:8]);
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_res, input logic [7:0] exp_stat);
    logic [7:0] v;
    rd(4'h5, v); check({tag, "_status"}, 32'(v), 32'(exp_stat));
    rd(4'h8, v); check({tag, "_r0"}, 32'(v), 32'(exp_res[7:0]));
    rd(4'h9, v); check({tag, "_r1"}, 32'(v), 32'(exp_res[15:8]));
    rd(4'hA, v); check({tag, "_r2"}, 32'(v), 32'(exp_res[23:16]));
    rd(4'hB, v); check({tag, "_r3"}, 32'(v), 32'(exp_res[31:24]));
  endtask

  initial begin
    logic [7:0] v;
    int low_cycles;

    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 4'h0; din = 8'h00;
    tick(2);
    rst = 1'b0;

    check("reset_dout", 32'(dout), 32'h00);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_rdy", 32'(rdy), 32'h1);
    rd(4'h5, v); check("reset_status", 32'(v), 32'h00);
    rd(4'hB, v); check("reset_r3", 32'(v), 32'h00);

    // 0x1234 * 0x5678 = 0x06260060
    load_ops(16'h1234, 16'h5678);
    wr(4'h4, 8'h00);
    tick(16);
    check_result("mul", 32'h0626_0060, 8'h40);
    rd(4'h5, v); check("mul_done_cleared", 32'(v), 32'h00);

    // 0xFFFF / 7 = 0x2492 remainder 1
    load_ops(16'hFFFF, 16'h0007);
    wr(4'h4, 8'h01);
    tick(16);
    check_result("div", 32'h0001_2492, 8'h40);

    // Divide by zero: quotient all ones, remainder = dividend, DZ set
    load_ops(16'h1234, 16'h0000);
    wr(4'h4, 8'h01);
    tick(16);
    check_result("divz", 32'h1234_FFFF, 8'h41);
    rd(4'h6, v); check("unmapped_6", 32'(v), 32'h00);

    // STATUS read in cycle 1 of a run: no stall, BUSY only
    load_ops(16'h0003, 16'h0005);
    wr(4'h4, 8'h00);
    cs = 1'b1; we = 1'b0; addr = 4'h5;
    #1;
    check("stat_read_rdy", 32'(rdy), 32'h1);
    tick(1);
    cs = 1'b0;
    check("stat_read_busy", 32'(dout), 32'h80);
    tick(15);
    rd(4'h5, v); check("stat_read_done", 32'(v), 32'h40);

    // R0 read held from cycle 1 stalls for cycles 1-16; previous R0 is 0x0F, so reload 7*9=0x3F
    load_ops(16'h0007, 16'h0009);
    wr(4'h4, 8'h00);
    cs = 1'b1; we = 1'b0; addr = 4'h8;
    #1;
    low_cycles = 0;
    for (int k = 1; k <= 16; k++) begin
      if (rdy == 1'b0) low_cycles++;
      tick(1);
    end
    check("stall_low_cycles", 32'(low_cycles), 32'd16);
    check("stall_rdy_c17", 32'(rdy), 32'h1);
    tick(1);
    cs = 1'b0;
    check("stall_dout_c18", 32'(dout), 32'h3F);

    // IE set; mid-run writes to A and CTRL must not disturb the running mul
    load_ops(16'h0100, 16'h0002);
    wr(4'h4, 8'h80);
    wr(4'h0, 8'hFF);
    wr(4'h1, 8'hFF);
    cs = 1'b1; we = 1'b1; addr = 4'h4; din = 8'h81;
    #1;
    check("busy_write_rdy", 32'(rdy), 32'h1);
    tick(1);
    cs = 1'b0; we = 1'b0;
    rd(4'h0, v); check("busy_operand_read", 32'(v), 32'hFF);
    rd(4'h4, v); check("busy_ctrl_ie_only", 32'(v), 32'h80);
    check("irq_low_running", 32'(irq), 32'h0);
    tick(11);
    check("irq_low_at_done", 32'(irq), 32'h0);
    tick(1);
    check("irq_high", 32'(irq), 32'h1);
    rd(4'h5, v); check("irq_status", 32'(v), 32'h40);
    check("irq_still_high", 32'(irq), 32'h1);
    tick(1);
    check("irq_cleared", 32'(irq), 32'h0);
    rd(4'h8, v); check("irq_r0", 32'(v), 32'h00);
    rd(4'h9, v); check("irq_r1", 32'(v), 32'h02);
    rd(4'hA, v); check("irq_r2", 32'(v), 32'h00);

    // Reset in cycle 8 of a mul aborts it and clears everything
    load_ops(16'h1234, 16'h5678);
    wr(4'h4, 8'h80);
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_dout", 32'(dout), 32'h00);
    check("rst_mid_irq", 32'(irq), 32'h0);
    check_result("rst_mid", 32'h0000_0000, 8'h00);
    rd(4'h4, v); check("rst_mid_ctrl", 32'(v), 32'h00);

    // 7 / 3 = 2 remainder 1 after the abort
    load_ops(16'h0007, 16'h0003);
    wr(4'h4, 8'h01);
    tick(16);
    check_result("post_rst_div", 32'h0001_0002, 8'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
